// File: rtl/conv_3x3_pkg.sv
// Shared definitions for the 3x3 convolution weight path: streamer FSM
// encoding, kernel geometry and address-width sizing.
package conv_3x3_pkg;

    localparam int KERNEL_SIZE  = 9;
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_REQ = 3'd1,
        ST_BURST    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Width needed to address every weight of a layer; never narrower than 1 bit.
    function automatic int addr_width_f(input int cin, input int cout, input int ksize);
        int total_s;
        total_s = cin * cout * ksize;
        return (total_s > 1) ? $clog2(total_s) : 1;
    endfunction

endpackage

// File: rtl/conv_3x3_weight_addr_gen.sv
// Linear weight-address walker: tap inner, input channel, output channel outer.
// Raises last_set once the final tap of the final set has been read.
module conv_3x3_weight_addr_gen
    import conv_3x3_pkg::*;
#(
    parameter int TAPS       = KERNEL_SIZE,
    parameter int CIN        = 64,
    parameter int COUT       = 128,
    parameter int ADDR_WIDTH = addr_width_f(CIN, COUT, TAPS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  tap_last,
    output logic                  last_set
);

    localparam int K_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int IC_W = (CIN > 1)  ? $clog2(CIN)  : 1;
    localparam int OC_W = (COUT > 1) ? $clog2(COUT) : 1;
    localparam logic [K_W-1:0]  K_LAST  = K_W'(TAPS - 1);
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(CIN - 1);
    localparam logic [OC_W-1:0] OC_LAST = OC_W'(COUT - 1);

    logic [K_W-1:0]        k_r;
    logic [IC_W-1:0]       ic_r;
    logic [OC_W-1:0]       oc_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  last_set_r;

    // Counter chain and address register, stepped once per memory read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_r        <= '0;
            ic_r       <= '0;
            oc_r       <= '0;
            addr_r     <= '0;
            last_set_r <= 1'b0;
        end else if (clear) begin
            k_r        <= '0;
            ic_r       <= '0;
            oc_r       <= '0;
            addr_r     <= '0;
            last_set_r <= 1'b0;
        end else if (advance) begin
            addr_r <= addr_r + ADDR_WIDTH'(1);
            if (k_r == K_LAST) begin
                k_r <= '0;
                if (ic_r == IC_LAST) begin
                    ic_r <= '0;
                    if (oc_r == OC_LAST) begin
                        oc_r       <= '0;
                        last_set_r <= 1'b1;
                    end else begin
                        oc_r <= oc_r + OC_W'(1);
                    end
                end else begin
                    ic_r <= ic_r + IC_W'(1);
                end
            end else begin
                k_r <= k_r + K_W'(1);
            end
        end
    end

    assign addr     = addr_r;
    assign tap_last = (k_r == K_LAST);
    assign last_set = last_set_r;

endmodule

// File: rtl/conv_3x3_weight_streamer.sv
// Streams 3x3 kernel weights from a synchronous weight memory as 9-word bursts,
// one burst per load_req, with a single-deep request queue and overrun flag.
module conv_3x3_weight_streamer
    import conv_3x3_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int KERNEL_SIZE     = conv_3x3_pkg::KERNEL_SIZE,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 128,
    parameter int ADDR_WIDTH      = addr_width_f(CHANNEL_NUM_IN, CHANNEL_NUM_OUT, KERNEL_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_req,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  valid_weight_out,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overrun
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    state_e                state_r;
    state_e                state_nxt_s;
    logic [DRAIN_W-1:0]    drain_cnt_r;
    logic                  pending_r;
    logic                  pending_nxt_s;
    logic                  err_r;
    logic                  err_nxt_s;
    logic                  rd_en_r;
    logic                  rd_en_d1_r;
    logic                  valid_r;
    logic                  busy_r;
    logic                  done_r;
    logic [DATA_WIDTH-1:0] weight_r;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic                  tap_last_s;
    logic                  last_set_s;
    logic                  layer_start_s;

    assign layer_start_s = start && (state_r == ST_IDLE);

    conv_3x3_weight_addr_gen #(
        .TAPS       (KERNEL_SIZE),
        .CIN        (CHANNEL_NUM_IN),
        .COUT       (CHANNEL_NUM_OUT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (layer_start_s),
        .advance  (rd_en_r),
        .addr     (addr_s),
        .tap_last (tap_last_s),
        .last_set (last_set_s)
    );

    // Next-state decode; BURST ends on the read of the final tap
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_WAIT_REQ;
                else       state_nxt_s = ST_IDLE;
            end
            ST_WAIT_REQ: begin
                if (load_req || pending_r) state_nxt_s = ST_BURST;
                else                       state_nxt_s = ST_WAIT_REQ;
            end
            ST_BURST: begin
                if (tap_last_s) state_nxt_s = ST_DRAIN;
                else            state_nxt_s = ST_BURST;
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    if (last_set_s) state_nxt_s = ST_DONE;
                    else            state_nxt_s = ST_WAIT_REQ;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Request queue (depth 1) and sticky overrun; the queue never survives into IDLE
    always_comb begin
        pending_nxt_s = pending_r;
        err_nxt_s     = err_r;
        case (state_r)
            ST_IDLE: begin
                pending_nxt_s = 1'b0;
                if (start) err_nxt_s = 1'b0;
                else       err_nxt_s = err_r;
            end
            ST_WAIT_REQ: begin
                if (load_req || pending_r) pending_nxt_s = 1'b0;
                else                       pending_nxt_s = pending_r;
            end
            ST_BURST, ST_DRAIN, ST_DONE: begin
                if (load_req) begin
                    if (pending_r) err_nxt_s = 1'b1;
                    else           pending_nxt_s = 1'b1;
                end else begin
                    pending_nxt_s = pending_r;
                end
            end
            default: begin
                pending_nxt_s = 1'b0;
                err_nxt_s     = err_r;
            end
        endcase
        if (state_nxt_s == ST_IDLE) pending_nxt_s = 1'b0;
        else                        pending_nxt_s = pending_nxt_s;
    end

    // FSM state, request bookkeeping and control outputs registered from next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= '0;
            pending_r   <= 1'b0;
            err_r       <= 1'b0;
            rd_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= (state_r == ST_DRAIN) ? drain_cnt_r + DRAIN_W'(1) : '0;
            pending_r   <= pending_nxt_s;
            err_r       <= err_nxt_s;
            rd_en_r     <= (state_nxt_s == ST_BURST);
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_DONE);
        end
    end

    // Read-data capture: memory answers one cycle after the strobe, output one more later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en_d1_r <= 1'b0;
            valid_r    <= 1'b0;
            weight_r   <= '0;
        end else begin
            rd_en_d1_r <= rd_en_r;
            valid_r    <= rd_en_d1_r;
            if (rd_en_d1_r) weight_r <= mem_rd_data;
        end
    end

    assign mem_rd_en        = rd_en_r;
    assign mem_addr         = addr_s;
    assign valid_weight_out = valid_r;
    assign weight_out       = weight_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign err_overrun      = err_r;

endmodule

// File: tb/tb_conv_3x3_weight_streamer.sv
// Bench for conv_3x3_weight_streamer on a 2x2-channel layer: an event-schedule
// reference model checked every cycle, plus literal timing/count expectations.
module tb_conv_3x3_weight_streamer;
    import conv_3x3_pkg::*;

    localparam int DW    = 32;
    localparam int CIN   = 2;
    localparam int COUT  = 2;
    localparam int KS    = 9;
    localparam int NSETS = CIN * COUT;
    localparam int AW    = addr_width_f(CIN, COUT, KS);
    localparam int MAXC  = 6000;
    localparam int NEVER = 1 << 30;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          load_req = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          valid_weight_out;
    logic [DW-1:0] weight_out;
    logic          busy;
    logic          done;
    logic          err_overrun;

    conv_3x3_weight_streamer #(
        .DATA_WIDTH      (DW),
        .KERNEL_SIZE     (KS),
        .CHANNEL_NUM_IN  (CIN),
        .CHANNEL_NUM_OUT (COUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .load_req         (load_req),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_rd_data      (mem_rd_data),
        .valid_weight_out (valid_weight_out),
        .weight_out       (weight_out),
        .busy             (busy),
        .done             (done),
        .err_overrun      (err_overrun)
    );

    always #5 clk = ~clk;

    // Synchronous weight memory: word at address a holds a+100
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= DW'(mem_addr) + 32'd100;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit checking = 1'b0;

    // Expected outputs per cycle
    bit exp_rd [MAXC];
    bit exp_valid [MAXC];
    bit exp_done [MAXC];
    bit exp_busy [MAXC];
    bit exp_err [MAXC];
    bit exp_zero [MAXC];
    int exp_addr [MAXC];
    int exp_data [MAXC];

    // Model state
    bit m_active = 1'b0;
    bit m_pending = 1'b0;
    bit m_err = 1'b0;
    int m_set = 0;
    int m_free_at = NEVER;
    int m_end_at = NEVER;

    // Observation records
    int            rd_cyc_q[$];
    int            val_cyc_q[$];
    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] word_q[$];
    int            done_cnt = 0;
    int            mk_rd = 0;
    int            mk_val = 0;
    int            mk_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic mark();
        mk_rd   = rd_cyc_q.size();
        mk_val  = val_cyc_q.size();
        mk_done = done_cnt;
    endtask

    // Model: a granted request at cycle c reads set s on c+1..c+9, emits on c+3..c+11,
    // and the next grant is possible at c+12; the last set ends the layer.
    task automatic model_step(input int c, input bit rst_v, input bit st, input bit lr);
        if (!rst_v) begin
            m_active = 1'b0; m_pending = 1'b0; m_err = 1'b0;
            m_free_at = NEVER; m_end_at = NEVER;
            for (int j = c; j < c + 14; j++) begin
                exp_rd[j] = 1'b0; exp_valid[j] = 1'b0; exp_done[j] = 1'b0;
            end
            exp_zero[c] = 1'b1; exp_addr[c] = 0; exp_data[c] = 0;
            exp_busy[c] = 1'b0; exp_err[c] = 1'b0;
        end else begin
            if (m_active && c == m_end_at) begin
                m_active = 1'b0; m_pending = 1'b0;
            end
            exp_busy[c] = m_active;
            exp_err[c]  = m_err;
            if (!m_active) begin
                if (st) begin
                    m_active = 1'b1; m_set = 0; m_pending = 1'b0; m_err = 1'b0;
                    m_free_at = c + 1; m_end_at = NEVER;
                end
            end else if (c >= m_free_at) begin
                if (lr || m_pending) begin
                    for (int k = 0; k < KS; k++) begin
                        exp_rd[c+1+k]    = 1'b1;
                        exp_addr[c+1+k]  = m_set * KS + k;
                        exp_valid[c+3+k] = 1'b1;
                        exp_data[c+3+k]  = m_set * KS + k + 100;
                    end
                    m_pending = 1'b0;
                    if (m_set == NSETS - 1) begin
                        exp_done[c+12] = 1'b1;
                        m_end_at  = c + 13;
                        m_free_at = NEVER;
                    end else begin
                        m_free_at = c + 12;
                    end
                    m_set++;
                end
            end else if (lr) begin
                if (m_pending) m_err = 1'b1;
                else           m_pending = 1'b1;
            end
        end
    endtask

    task automatic step(input bit rst_v, input bit st, input bit lr);
        reset    = rst_v;
        start    = st && rst_v;
        load_req = lr && rst_v;
        model_step(cyc, rst_v, st && rst_v, lr && rst_v);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (checking) begin
            chk("mem_rd_en", mem_rd_en, exp_rd[cyc]);
            if (exp_rd[cyc] || exp_zero[cyc]) chk("mem_addr", mem_addr, exp_addr[cyc]);
            chk("valid_weight_out", valid_weight_out, exp_valid[cyc]);
            if (exp_valid[cyc] || exp_zero[cyc]) chk("weight_out", weight_out, exp_data[cyc]);
            chk("done", done, exp_done[cyc]);
            chk("busy", busy, exp_busy[cyc]);
            chk("err_overrun", err_overrun, exp_err[cyc]);
            if (mem_rd_en) begin
                rd_cyc_q.push_back(cyc);
                addr_q.push_back(mem_addr);
            end
            if (valid_weight_out) begin
                val_cyc_q.push_back(cyc);
                word_q.push_back(weight_out);
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checking = 1'b1;

        // Full layer: start at 2, requests at 10, 24, 40, 56
        mark();
        for (int i = 0; i < 75; i++)
            step(1'b1, i == 2, i == 10 || i == 24 || i == 40 || i == 56);
        chk("a_read_count", rd_cyc_q.size() - mk_rd, 36);
        chk("a_word_count", val_cyc_q.size() - mk_val, 36);
        if (rd_cyc_q.size() - mk_rd >= 9 && val_cyc_q.size() - mk_val >= 9) begin
            for (int i = 0; i < 9; i++) begin
                chk("a_rd_cycle", rd_cyc_q[mk_rd+i], 11 + i);
                chk("a_addr", addr_q[mk_rd+i], i);
                chk("a_valid_cycle", val_cyc_q[mk_val+i], 13 + i);
            end
        end
        if (val_cyc_q.size() - mk_val == 36) begin
            for (int i = 0; i < 36; i++) chk("a_word", word_q[mk_val+i], 100 + i);
        end
        chk("a_done_pulses", done_cnt - mk_done, 1);
        chk("a_err_overrun", err_overrun, 1'b0);

        // Pending service spacing, then three requests inside one burst
        mark();
        for (int i = 0; i < 60; i++) begin
            if (i == 28) begin
                chk("b_read_count", rd_cyc_q.size() - mk_rd, 18);
                if (rd_cyc_q.size() - mk_rd == 18)
                    chk("b_pending_spacing", rd_cyc_q[mk_rd+9] - rd_cyc_q[mk_rd], 12);
                mark();
            end
            step(1'b1, i == 1,
                 i == 3 || i == 6 || i == 30 || i == 32 || i == 34 || i == 36);
        end
        chk("b_word_count", val_cyc_q.size() - mk_val, 18);
        chk("b_err_overrun", err_overrun, 1'b1);
        chk("b_done_pulses", done_cnt - mk_done, 1);

        // Reset on the 5th word, request without start, restart, start while busy,
        // then start+load_req together in IDLE
        mark();
        for (int i = 0; i <= 100; i++) begin
            if (i == 12 || i == 80) mark();
            if (i == 20) begin
                chk("c_reads_after_reset", rd_cyc_q.size() - mk_rd, 0);
                chk("c_words_after_reset", val_cyc_q.size() - mk_val, 0);
            end
            if (i == 35) begin
                chk("c_restart_reads", rd_cyc_q.size() - mk_rd, 9);
                if (rd_cyc_q.size() > mk_rd) chk("c_restart_addr", addr_q[mk_rd], 0);
            end
            if (i == 47 && rd_cyc_q.size() - mk_rd > 9)
                chk("d_addr_after_busy_start", addr_q[mk_rd+9], 9);
            if (i == 95) chk("d_no_burst_on_start_req", rd_cyc_q.size() - mk_rd, 0);
            if (i == 100) chk("d_burst_after_req", rd_cyc_q.size() - mk_rd, 3);
            step(!(i == 10 || i == 11),
                 i == 1 || i == 20 || i == 26 || i == 80,
                 i == 3 || i == 15 || i == 22 || i == 36 || i == 50 || i == 64 ||
                 i == 80 || i == 96);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 399) != 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 5) == 0);
        end

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
